// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with a one-entry skid buffer.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   redirect/_pc      - taken branch/jump; reload pc (bit 0 forced to 0)
//   stall             - decode cannot take if_instr this cycle
//   halt              - decode holds HALT; stop fetching until reset
//   imem_rd/_addr     - instruction memory request; address is always pc
//   imem_data/_done   - returned instruction, valid when imem_done=1
//   imem_err          - memory fault, qualified by imem_done
//   if_valid/_instr/_next_pc - fetched instruction and its address + 2
//   err               - sticky fault (memory fault or odd redirect target)
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_next_pc,
  output logic        err
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALTED} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] next_pc;
  } fetch_ent_t;

  state_t      state;
  logic [15:0] pc;
  fetch_ent_t  out_ent;
  fetch_ent_t  skid;
  logic [15:0] pc_inc;

  // Wraps modulo 2^16 naturally.
  assign pc_inc     = pc + 16'd2;

  assign imem_rd    = (state == S_REQ);
  assign imem_addr  = pc;
  assign if_instr   = out_ent.instr;
  assign if_next_pc = out_ent.next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= '0;
      if_valid <= 1'b0;
      out_ent  <= '0;
      skid     <= '0;
      err      <= 1'b0;
    end else if (halt) begin
      // halt wins over everything else; pc is frozen where it is.
      state    <= S_HALTED;
      if_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            // Same-cycle imem_data belongs to the wrong path: dropped.
            pc       <= {redirect_pc[15:1], 1'b0};
            if_valid <= 1'b0;
            skid     <= '0;
            if (redirect_pc[0]) err <= 1'b1;
          end else if (imem_done) begin
            if (imem_err) err <= 1'b1;
            pc <= pc_inc;
            if (!stall || !if_valid) begin
              out_ent  <= '{instr: imem_data, next_pc: pc_inc};
              if_valid <= 1'b1;
            end else begin
              // Decode is blocked on a live instruction: park this one.
              skid  <= '{instr: imem_data, next_pc: pc_inc};
              state <= S_HOLD;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc       <= {redirect_pc[15:1], 1'b0};
            if_valid <= 1'b0;
            skid     <= '0;
            state    <= S_REQ;
            if (redirect_pc[0]) err <= 1'b1;
          end else if (!stall) begin
            out_ent  <= skid;
            if_valid <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_HALTED: ;  // only reset leaves
        default:  state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: redirect  input  1  branch/jump taken; load redirect_pc.
REQ-004 SHALL: redirect_pc  input  16  target PC for redirect.
REQ-005 SHALL: stall  input  1  decode cannot accept if_instr this cycle.
REQ-006 SHALL: halt  input  1  decode holds HALT instruction; stop fetching.
REQ-007 SHALL: imem_rd  output  1  instruction memory read request.
REQ-008 SHALL: imem_addr  output  16  read address, equal to pc.
REQ-009 SHALL: imem_data  input  16  instruction returned; valid only when imem_done=1.
REQ-010 SHALL: imem_done  input  1  read complete for imem_addr presented this cycle.
REQ-011 SHALL: imem_err  input  1  memory fault, meaningful only with imem_done=1.
REQ-012 SHALL: if_valid  output  1  if_instr/if_next_pc hold a live instruction.
REQ-013 SHALL: if_instr  output  16  fetched instruction to decode.
REQ-014 SHALL: if_next_pc  output  16  fetched instruction address + 2.
REQ-015 SHALL: err  output  1  sticky fault flag.

Function
REQ-016 SHALL: states REQ, HOLD, HALTED; one internal 16-bit pc, one 16-bit skid buffer (instr + next_pc).
REQ-017 SHALL: REQ: imem_rd=1, imem_addr=pc; HOLD and HALTED: imem_rd=0, imem_addr=pc.
REQ-018 SHALL: REQ, imem_done=1, (stall=0 or if_valid=0): if_instr<=imem_data, if_next_pc<=pc+2, if_valid<=1, pc<=pc+2, stay REQ.
REQ-019 SHALL: REQ, imem_done=1, stall=1, if_valid=1: skid buffer<=imem_data/pc+2, pc<=pc+2, go HOLD; if outputs unchanged.
REQ-020 SHALL: REQ, imem_done=0, stall=0: if_valid<=0; with stall=1: if outputs held.
REQ-021 SHALL: HOLD, stall=0: if outputs<=skid buffer, if_valid<=1, go REQ; stall=1: remain HOLD, all held.
REQ-022 SHALL: redirect=1 in REQ or HOLD: pc<={redirect_pc[15:1],1'b0}, if_valid<=0, skid buffer discarded, imem_data of same cycle discarded, go REQ; redirect overrides stall and imem_done.
REQ-023 SHALL: halt=1 in any state: go HALTED, if_valid<=0, pc unchanged; halt overrides redirect, stall, imem_done.
REQ-024 SHALL: HALTED exits only on rst; redirect, stall, imem_done ignored.
REQ-025 SHALL: pc arithmetic modulo 2^16; 0xFFFE + 2 = 0x0000.
REQ-026 SHALL: err<=1 on imem_done=1 with imem_err=1 (instruction still accepted per REQ-018/019), or on redirect=1 with redirect_pc[0]=1; err stays 1 until rst.
REQ-027 SHALL: fetch throughput one instruction per cycle when imem_done=1 every cycle and stall=0; latency imem_done -> if_valid one cycle.
REQ-028 SHALL: at most one instruction in skid buffer; no fetch request while HOLD.

Reset
REQ-029 SHALL: rst=1 at edge: state<=REQ, pc<=0x0000, if_valid<=0, if_instr<=0x0000, if_next_pc<=0x0000, skid buffer cleared, err<=0.
REQ-030 SHALL: rst overrides all other inputs, including mid-HOLD and HALTED; imem_rd=1, imem_addr=0x0000 first cycle after reset.

Verification
REQ-031 SHALL: reset, imem_done=1 each cycle, data 0x1111,0x2222 -> if_instr 0x1111/if_next_pc 0x0002 then 0x2222/0x0004, if_valid=1 continuously.
REQ-032 SHALL: if_valid=1 holding 0x1111, stall=1 while done returns 0x2222 -> HOLD, if_instr stays 0x1111, imem_rd=0; stall=0 -> if_instr=0x2222 next cycle, then fetch resumes at 0x0004.
REQ-033 SHALL: in HOLD, redirect=1, redirect_pc=0x0040 -> if_valid=0, buffered 0x2222 dropped, imem_addr=0x0040 next cycle.
REQ-034 SHALL: halt=1 with simultaneous redirect=1 -> HALTED, imem_rd=0, pc unchanged, if_valid=0; later stimulus ignored until rst returns pc=0x0000.
REQ-035 SHALL: redirect_pc=0xFFFE then done -> if_next_pc=0x0000, next imem_addr=0x0000; redirect_pc=0x0013 -> err=1, imem_addr=0x0012, err held until rst.
